// File: rtl/vecmac_pkg.sv
// Shared constants and width helpers for the vecmac accumulator slice.
// Optional feature macro: VECMAC_LAST_EN (early vector termination via in_last).
package vecmac_pkg;

  localparam int PROD_W      = 16;
  localparam int VEC_LEN_DEF = 8;

  // Width of the beat counter; a 2-beat vector still needs one bit.
  function automatic int cnt_width(input int vec_len);
    return (vec_len < 2) ? 1 : $clog2(vec_len);
  endfunction

  // Smallest accumulator that cannot overflow for vec_len full-scale products.
  function automatic int acc_width(input int vec_len);
    return PROD_W + $clog2(vec_len);
  endfunction

endpackage

// File: rtl/vecmac_accumulator_fifo.sv
// result_fifo2: 2-entry synchronous FIFO with the head entry always visible.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push_i, din_i  write request and data (ignored when full unless popping)
//   pop_i          read request (ignored when empty)
//   full_o/empty_o occupancy flags
//   head_o         oldest entry, zero when empty
// A pop and a push in the same cycle are both honoured even when full.
module result_fifo2 #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop_eff, push_eff;

  always_comb begin
    pop_eff  = pop_i && (cnt_q != 2'd0);
    push_eff = push_i && ((cnt_q != 2'd2) || pop_eff);
    e0_d     = e0_q;
    e1_d     = e1_q;
    cnt_d    = cnt_q;
    // Shift-out pop first so a simultaneous push lands in the freed slot.
    if (pop_eff) begin
      e0_d  = e1_q;
      e1_d  = '0;
      cnt_d = cnt_q - 2'd1;
    end
    if (push_eff) begin
      if (cnt_d == 2'd0) e0_d = din_i;
      else               e1_d = din_i;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = empty_o ? '0 : e0_q;

endmodule

// File: rtl/vecmac_accumulator.sv
// vecmac_accumulator: sums VEC_LEN unsigned products into a dot product and
// queues results in a 2-entry FIFO. The input stream cannot be stalled, so a
// result that finds the FIFO full is dropped and flagged on drop_err (sticky).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 discard the partial vector (FIFO untouched)
//   in_valid, in_product  product beat
//   in_last               (VECMAC_LAST_EN only) ends the vector early
//   out_valid, out_ready  result handshake; out_sum is the head result
//   out_len               (VECMAC_LAST_EN only) beat count of the head result
//   busy, beat_cnt        partial-vector status
//   drop_err              sticky result-lost flag
// Optional feature macro: VECMAC_LAST_EN.
module vecmac_accumulator
  import vecmac_pkg::*;
#(
  parameter  int VEC_LEN = VEC_LEN_DEF,
  parameter  int ACC_W   = acc_width(VEC_LEN_DEF),
  localparam int CNT_W   = cnt_width(VEC_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_product,
`ifdef VECMAC_LAST_EN
  input  logic              in_last,
  output logic [CNT_W:0]    out_len,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              busy,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              drop_err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

`ifdef VECMAC_LAST_EN
  localparam int FIFO_W = ACC_W + CNT_W + 1;
`else
  localparam int FIFO_W = ACC_W;
`endif

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic              beat, last_flag, last_beat;
  logic [ACC_W-1:0]  sum_nxt;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [FIFO_W-1:0] fifo_din, fifo_head;

`ifdef VECMAC_LAST_EN
  assign last_flag = in_last;
`else
  assign last_flag = 1'b0;
`endif

  assign fifo_pop = out_ready && !fifo_empty;

  always_comb begin
    beat      = in_valid && !flush;
    // First beat of a vector loads rather than adds, so acc need not be cleared.
    sum_nxt   = ((cnt_q == '0) ? '0 : acc_q) + ACC_W'(in_product);
    last_beat = beat && ((cnt_q == LAST_CNT) || last_flag);
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (beat) begin
      if (last_beat) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum_nxt;
        cnt_d = cnt_q + 1'b1;
      end
    end
    drop_d = drop_q || (last_beat && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

`ifdef VECMAC_LAST_EN
  assign fifo_din = {({1'b0, cnt_q} + 1'b1), sum_nxt};
  assign out_len  = fifo_head[FIFO_W-1:ACC_W];
`else
  assign fifo_din = sum_nxt;
`endif

  result_fifo2 #(.W(FIFO_W)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (last_beat),
    .din_i  (fifo_din),
    .pop_i  (fifo_pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

  assign out_valid = !fifo_empty;
  assign out_sum   = fifo_head[ACC_W-1:0];
  assign busy      = (cnt_q != '0);
  assign beat_cnt  = cnt_q;
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_vecmac_accumulator.sv
module tb_vecmac_accumulator;

  localparam int VLEN = 8;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_product;
  logic        out_valid, busy, drop_err;
  logic [18:0] out_sum;
  logic [2:0]  beat_cnt;
  logic        in_last;
`ifdef VECMAC_LAST_EN
  logic [3:0]  out_len;
`endif

  vecmac_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_product(in_product),
`ifdef VECMAC_LAST_EN
    .in_last   (in_last),
    .out_len   (out_len),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .busy      (busy),
    .beat_cnt  (beat_cnt),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference model: the open vector as a list of products, results as a queue.
  int part[$];
  int mq_sum[$];
  int mq_len[$];
  bit m_drop;
  bit rdy_g;

  task automatic model_edge(input bit r, input bit f, input bit v, input int p,
                            input bit rd, input bit l);
    int s;
    if (r) begin
      part.delete();
      mq_sum.delete();
      mq_len.delete();
      m_drop = 0;
      return;
    end
    if (rd && mq_sum.size() > 0) begin
      void'(mq_sum.pop_front());
      void'(mq_len.pop_front());
    end
    if (f) part.delete();
    else if (v) begin
      part.push_back(p);
      if (part.size() == VLEN || l) begin
        s = 0;
        foreach (part[i]) s += part[i];
        if (mq_sum.size() < 2) begin
          mq_sum.push_back(s);
          mq_len.push_back(part.size());
        end else m_drop = 1;
        part.delete();
      end
    end
  endtask

  task automatic compare_all();
    check("out_valid", out_valid, mq_sum.size() != 0);
    check("out_sum", out_sum, (mq_sum.size() != 0) ? mq_sum[0] : 0);
    check("busy", busy, part.size() != 0);
    check("beat_cnt", beat_cnt, part.size());
    check("drop_err", drop_err, m_drop);
`ifdef VECMAC_LAST_EN
    check("out_len", out_len, (mq_len.size() != 0) ? mq_len[0] : 0);
`endif
  endtask

  task automatic cyc(input bit r, input bit f, input bit v, input int p, input bit l);
    rst = r; flush = f; in_valid = v; in_product = p[15:0]; out_ready = rdy_g; in_last = l;
    @(posedge clk);
    model_edge(r, f, v, p & 32'hFFFF, rdy_g, l);
    #1;
    compare_all();
  endtask

  task automatic beat(input int p);
    cyc(0, 0, 1, p, 0);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    rdy_g = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("reset_valid", out_valid, 0);
    check("reset_sum", out_sum, 0);
    check("reset_cnt", beat_cnt, 0);

    // 1: products 1..8, ready held high
    rdy_g = 1;
    for (int i = 1; i <= 8; i++) beat(i);
    check("t1_valid", out_valid, 1);
    check("t1_sum", out_sum, 36);
    idle();
    check("t1_valid_low", out_valid, 0);

    // 2: full-scale products
    rdy_g = 0;
    for (int i = 0; i < 8; i++) beat(16'hFFFF);
    check("t2_sum", out_sum, 524280);
    rdy_g = 1;
    idle();

    // 3: gapped beats of 2
    rdy_g = 0;
    for (int i = 0; i < 8; i++) begin
      beat(2);
      if (i < 7) begin
        check("t3_busy", busy, 1);
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) idle();
      end
    end
    check("t3_sum", out_sum, 16);
    check("t3_busy_end", busy, 0);
    rdy_g = 1;
    idle();

    // 4: backpressure and drop
    rdy_g = 0;
    for (int k = 1; k <= 3; k++) for (int i = 0; i < 8; i++) beat(k);
    check("t4_drop", drop_err, 1);
    check("t4_head", out_sum, 8);
    rdy_g = 1;
    idle();
    check("t4_second", out_sum, 16);
    idle();
    check("t4_empty", out_valid, 0);
    check("t4_drop_sticky", drop_err, 1);

    // 4b: full FIFO, push and pop in the same cycle
    rdy_g = 0;
    cyc(1, 0, 0, 0, 0);
    for (int k = 2; k <= 3; k++) for (int i = 0; i < 8; i++) beat(k);
    for (int i = 0; i < 7; i++) beat(4);
    rdy_g = 1;
    beat(4);
    check("t4b_no_drop", drop_err, 0);
    check("t4b_head", out_sum, 24);
    idle();
    check("t4b_tail", out_sum, 32);
    idle();

    // 5: flush discards the 9s, including the beat issued with flush
    rdy_g = 0;
    for (int i = 0; i < 3; i++) beat(9);
    cyc(0, 1, 1, 9, 0);
    check("t5_cnt_flushed", beat_cnt, 0);
    for (int i = 0; i < 8; i++) beat(2);
    check("t5_sum", out_sum, 16);
    rdy_g = 1;
    idle();
    check("t5_single", out_valid, 0);

    // 6: reset mid-operation
    rdy_g = 0;
    for (int i = 0; i < 8; i++) beat(1);
    for (int i = 0; i < 5; i++) beat(1);
    cyc(1, 0, 0, 0, 0);
    check("t6_valid", out_valid, 0);
    check("t6_sum", out_sum, 0);
    check("t6_busy", busy, 0);
    check("t6_cnt", beat_cnt, 0);
    for (int i = 0; i < 8; i++) beat(1);
    check("t6_after", out_sum, 8);
    rdy_g = 1;
    idle();
`ifdef VECMAC_LAST_EN
    rdy_g = 0;
    beat(5);
    beat(6);
    cyc(0, 0, 1, 7, 1);
    check("t6_last_sum", out_sum, 18);
    check("t6_last_len", out_len, 3);
    rdy_g = 1;
    idle();
`endif

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int p;
      bit r, f, v, l;
      r = ($urandom_range(0, 499) == 0);
      f = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 9) < 7);
      p = ($urandom_range(0, 3) == 0) ? 32'hFFFF : int'($urandom_range(0, 65535));
`ifdef VECMAC_LAST_EN
      l = ($urandom_range(0, 5) == 0);
`else
      l = 0;
`endif
      rdy_g = ($urandom_range(0, 2) == 0);
      cyc(r, f, v, p, l);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
